// File: rtl/bp_cce_mem_responder_pkg.sv
// Shared types for the CCE-MEM responder.
// Holds the processor-configuration constants, the command/size enums, the
// message struct that rides on both the command and the response channel,
// and the responder FSM state encoding. It also provides a small size helper.
package bp_cce_mem_responder_pkg;

  localparam int paddr_width_p      = 40;
  localparam int cce_block_width_p  = 512;
  localparam int lce_id_width_p     = 2;
  localparam int lce_max_assoc_p    = 8;
  localparam int way_id_width_lp    = $clog2(lce_max_assoc_p);
  localparam int coh_state_width_lp = 3;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,  // cached read-miss fill
    e_cce_mem_wr    = 4'd1,  // cached write-miss fill
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_wb    = 4'd4   // full-block writeback
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [1:0] {
    e_mem_size_1 = 2'd0,
    e_mem_size_2 = 2'd1,
    e_mem_size_4 = 2'd2,
    e_mem_size_8 = 2'd3
  } bp_cce_mem_req_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]     lce_id;
    logic [way_id_width_lp-1:0]    way_id;
    logic [coh_state_width_lp-1:0] state;
    logic                          speculative;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_cce_mem_payload_s          payload;
    bp_cce_mem_req_size_e         size;
    logic [paddr_width_p-1:0]     addr;
    bp_cce_mem_cmd_type_e         msg_type;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_wait = 2'd1,
    e_resp = 2'd2
  } bp_cce_mem_resp_state_e;

  // Number of bytes moved by an uncached access of the given size.
  function automatic logic [3:0] size_bytes(bp_cce_mem_req_size_e size_i);
    return 4'd1 << size_i;
  endfunction

endpackage

// File: rtl/bp_cce_mem_responder_if.sv
// CCE-MEM channel between a command issuer (master) and the memory
// responder (slave).
//   mem_cmd / mem_cmd_v / mem_cmd_ready : command channel
//   mem_resp / mem_resp_v / mem_resp_yumi : response channel
//   state : responder FSM state, exported for observation only
// Handshake: a command transfers on a rising clock edge where
// mem_cmd_v & mem_cmd_ready are both 1; the issuer may drop mem_cmd_v at any
// time without effect. A response is offered while mem_resp_v=1 and held
// stable until the consumer raises mem_resp_yumi (only while mem_resp_v=1),
// which retires it on that edge.
interface bp_cce_mem_responder_if;
  import bp_cce_mem_responder_pkg::*;

  bp_cce_mem_msg_s        mem_cmd;
  logic                   mem_cmd_v;
  logic                   mem_cmd_ready;
  bp_cce_mem_msg_s        mem_resp;
  logic                   mem_resp_v;
  logic                   mem_resp_yumi;
  bp_cce_mem_resp_state_e state;

  modport master (
    output mem_cmd, mem_cmd_v, mem_resp_yumi,
    input  mem_cmd_ready, mem_resp, mem_resp_v, state
  );

  modport slave (
    input  mem_cmd, mem_cmd_v, mem_resp_yumi,
    output mem_cmd_ready, mem_resp, mem_resp_v, state
  );
endinterface

// File: rtl/bp_cce_mem_responder_byte_merge.sv
// Combinational byte lane merge/extract for uncached accesses.
//   block_i  : stored block
//   offset_i : byte offset within the block (aligned down to size here)
//   size_i   : access size (1/2/4/8 bytes)
//   data_i   : write data, low bytes used
//   merged_o : block_i with the addressed bytes replaced by data_i
//   rdata_o  : addressed bytes, zero-extended to 64 bits
module bp_cce_mem_responder_byte_merge
  import bp_cce_mem_responder_pkg::*;
#(
  parameter int block_width_p    = cce_block_width_p,
  parameter int lg_block_bytes_p = 6
) (
  input  logic [block_width_p-1:0]    block_i,
  input  logic [lg_block_bytes_p-1:0] offset_i,
  input  bp_cce_mem_req_size_e        size_i,
  input  logic [63:0]                 data_i,
  output logic [block_width_p-1:0]    merged_o,
  output logic [63:0]                 rdata_o
);

  logic [3:0]                  nbytes;
  logic [lg_block_bytes_p-1:0] aligned;
  logic [lg_block_bytes_p-1:0] byte_idx;

  assign nbytes  = size_bytes(size_i);
  assign aligned = offset_i & ~lg_block_bytes_p'(nbytes - 4'd1);

  always_comb begin
    merged_o = block_i;
    rdata_o  = '0;
    byte_idx = aligned;
    for (int b = 0; b < 8; b++) begin
      // aligned is a multiple of nbytes, so OR-ing the lane number is an add.
      byte_idx = aligned | lg_block_bytes_p'(b);
      if (4'(b) < nbytes) begin
        merged_o[{byte_idx, 3'b000} +: 8] = data_i[b*8 +: 8];
        rdata_o[b*8 +: 8]                 = block_i[{byte_idx, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/bp_cce_mem_responder.sv
// Memory-side endpoint of the CCE-MEM interface: a block-granular backing
// store that answers one command at a time after latency_p wait cycles.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   mem_if         : slave side of the CCE-MEM channel (command in, response out)
//   busy_o         : high whenever the FSM is not idle
// Writes commit on the accept edge and the response is computed there too;
// with one outstanding command nothing can change the block before the
// response is consumed.
module bp_cce_mem_responder
  import bp_cce_mem_responder_pkg::*;
#(
  parameter int mem_els_p = 64,
  parameter int latency_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bp_cce_mem_responder_if.slave         mem_if,
  output logic                          busy_o
);

  localparam int lg_block_bytes_lp = $clog2(cce_block_width_p / 8);
  localparam int index_width_lp    = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int cnt_width_lp      = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  bp_cce_mem_resp_state_e        state_q;
  logic [cnt_width_lp-1:0]       cnt_q;
  logic                          ready_q, resp_v_q, busy_q;
  bp_cce_mem_msg_s               resp_q, resp_d, cmd;
  logic [cce_block_width_p-1:0]  mem_q [mem_els_p];

  logic                          accept, wr_en;
  logic [index_width_lp-1:0]     idx;
  logic [cce_block_width_p-1:0]  block_rd, merged, wr_block, resp_data;
  logic [63:0]                   uc_rdata;

  assign cmd      = mem_if.mem_cmd;
  assign accept   = mem_if.mem_cmd_v & ready_q;
  // Upper address bits are dropped, so addresses alias modulo mem_els_p blocks.
  assign idx      = cmd.addr[lg_block_bytes_lp +: index_width_lp];
  assign block_rd = mem_q[idx];

  bp_cce_mem_responder_byte_merge #(
    .block_width_p    (cce_block_width_p),
    .lg_block_bytes_p (lg_block_bytes_lp)
  ) u_byte_merge (
    .block_i  (block_rd),
    .offset_i (cmd.addr[lg_block_bytes_lp-1:0]),
    .size_i   (cmd.size),
    .data_i   (cmd.data[63:0]),
    .merged_o (merged),
    .rdata_o  (uc_rdata)
  );

  always_comb begin
    wr_en     = 1'b0;
    wr_block  = cmd.data;
    resp_data = '0;
    case (cmd.msg_type)
      e_cce_mem_rd, e_cce_mem_wr: resp_data = block_rd;
      e_cce_mem_uc_rd:            resp_data = cce_block_width_p'(uc_rdata);
      e_cce_mem_uc_wr: begin
        wr_en    = accept;
        wr_block = merged;
      end
      e_cce_mem_wb:               wr_en = accept;
      default: ;  // unknown type: no write, zero data
    endcase
    resp_d      = cmd;
    resp_d.data = resp_data;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < mem_els_p; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= wr_block;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      resp_v_q <= 1'b0;
      busy_q   <= 1'b0;
      resp_q   <= '0;
    end else begin
      case (state_q)
        e_idle: begin
          if (accept) begin
            resp_q  <= resp_d;
            cnt_q   <= cnt_width_lp'(latency_p);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (latency_p > 0) begin
              state_q <= e_wait;
            end else begin
              state_q  <= e_resp;
              resp_v_q <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        e_wait: begin
          cnt_q <= cnt_q - cnt_width_lp'(1);
          if (cnt_q == cnt_width_lp'(1)) begin
            state_q  <= e_resp;
            resp_v_q <= 1'b1;
          end
        end
        e_resp: begin
          // No accept on the yumi edge: ready rises only once back in idle.
          if (mem_if.mem_resp_yumi) begin
            state_q  <= e_idle;
            resp_v_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= e_idle;
          resp_v_q <= 1'b0;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_if.mem_cmd_ready = ready_q;
  assign mem_if.mem_resp_v    = resp_v_q;
  assign mem_if.mem_resp      = resp_q;
  assign mem_if.state         = state_q;
  assign busy_o               = busy_q;

  a_known_cmd_type: assert property (@(posedge clk_i) disable iff (reset_i)
    accept |-> (cmd.msg_type inside {e_cce_mem_rd, e_cce_mem_wr, e_cce_mem_uc_rd,
                                     e_cce_mem_uc_wr, e_cce_mem_wb}));

endmodule

// File: tb/tb_bp_cce_mem_responder.sv
// Bench for bp_cce_mem_responder: one instance with latency 4, one with
// latency 0, checked against a byte-array memory model.
module tb_bp_cce_mem_responder;
  import bp_cce_mem_responder_pkg::*;

  localparam int MSG_W = cce_mem_msg_width_lp;
  localparam bit L4 = 1'b0;
  localparam bit L0 = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bp_cce_mem_responder_if if4 ();
  bp_cce_mem_responder_if if0 ();
  logic busy4, busy0;

  bp_cce_mem_responder #(.mem_els_p(64), .latency_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .mem_if(if4.slave), .busy_o(busy4));
  bp_cce_mem_responder #(.mem_els_p(64), .latency_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .mem_if(if0.slave), .busy_o(busy0));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference memory: 64 blocks x 64 bytes = 4096 bytes per instance.
  logic [7:0] ref_mem [2][4096];
  logic [MSG_W-1:0] exp_q [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input bit z, input logic v, input bp_cce_mem_msg_s m);
    if (z) begin if0.mem_cmd_v = v; if0.mem_cmd = m; end
    else   begin if4.mem_cmd_v = v; if4.mem_cmd = m; end
  endtask

  task automatic set_yumi(input bit z, input logic y);
    if (z) if0.mem_resp_yumi = y; else if4.mem_resp_yumi = y;
  endtask

  function automatic logic get_ready(input bit z);
    return z ? if0.mem_cmd_ready : if4.mem_cmd_ready;
  endfunction
  function automatic logic get_v(input bit z);
    return z ? if0.mem_resp_v : if4.mem_resp_v;
  endfunction
  function automatic logic get_busy(input bit z);
    return z ? busy0 : busy4;
  endfunction
  function automatic bp_cce_mem_msg_s get_resp(input bit z);
    return z ? if0.mem_resp : if4.mem_resp;
  endfunction

  function automatic bp_cce_mem_msg_s mk_msg(input bp_cce_mem_cmd_type_e t,
                                             input logic [39:0] a,
                                             input bp_cce_mem_req_size_e s);
    bp_cce_mem_msg_s m;
    m = '0;
    m.msg_type = t;
    m.addr = a;
    m.size = s;
    m.payload.lce_id = 2'($urandom());
    m.payload.way_id = 3'($urandom());
    m.payload.state = 3'($urandom());
    m.payload.speculative = 1'($urandom());
    for (int i = 0; i < 16; i++) m.data[i*32 +: 32] = $urandom();
    return m;
  endfunction

  task automatic clear_model();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 4096; i++) ref_mem[z][i] = 8'h00;
  endtask

  // Behavioural model: memory as a flat byte array, address taken mod 4096.
  task automatic model_apply(input bit z, input bp_cce_mem_msg_s m,
                             output bp_cce_mem_msg_s e);
    int base, off, n, a;
    base = (int'(m.addr % 40'd4096) / 64) * 64;
    off = int'(m.addr % 40'd64);
    n = 1 << int'(m.size);
    a = off - (off % n);
    e = m;
    e.data = '0;
    case (m.msg_type)
      e_cce_mem_rd, e_cce_mem_wr:
        for (int i = 0; i < 64; i++) e.data[i*8 +: 8] = ref_mem[z][base + i];
      e_cce_mem_wb:
        for (int i = 0; i < 64; i++) ref_mem[z][base + i] = m.data[i*8 +: 8];
      e_cce_mem_uc_wr:
        for (int i = 0; i < n; i++) ref_mem[z][base + a + i] = m.data[i*8 +: 8];
      e_cce_mem_uc_rd:
        for (int i = 0; i < n; i++) e.data[i*8 +: 8] = ref_mem[z][base + a + i];
      default: ;
    endcase
  endtask

  // Offer a command until accepted; returns just after the accept edge.
  task automatic issue(input bit z, input bp_cce_mem_msg_s m, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      drive(z, 1'b1, m);
      if (get_ready(z)) begin
        @(posedge clk);
        #1;
        drive(z, 1'b0, m);
        ok = 1'b1;
      end
    end
    n_cmp++;
    if (!ok) begin
      drive(z, 1'b0, m);
      n_fail++;
      $display("FAIL issue_timeout: ready stayed 0, required 1 within 64 cycles");
    end
  endtask

  // Returns at the first negedge where the response is valid;
  // lat = number of negedges seen before it.
  task automatic wait_resp(input bit z, input int max_c, output bit got,
                           output int lat, output bp_cce_mem_msg_s r);
    got = 1'b0;
    lat = 0;
    r = '0;
    for (int c = 0; c < max_c && !got; c++) begin
      @(negedge clk);
      if (get_v(z)) begin
        got = 1'b1;
        lat = c;
        r = get_resp(z);
      end
    end
  endtask

  task automatic yumi_pulse(input bit z);
    set_yumi(z, 1'b1);
    @(posedge clk);
    #1;
    set_yumi(z, 1'b0);
  endtask

  // Full transaction with latency and response checks.
  task automatic xact(input bit z, input bp_cce_mem_msg_s m, input string name,
                      output bp_cce_mem_msg_s r);
    bp_cce_mem_msg_s e;
    bit ok, got;
    int lat, req_lat;
    r = '0;
    req_lat = z ? 0 : 4;
    issue(z, m, ok);
    if (ok) begin
      model_apply(z, m, e);
      wait_resp(z, 64, got, lat, r);
      n_cmp++;
      if (!got) begin
        n_fail++;
        $display("FAIL %s_resp_timeout: valid=0, required 1", name);
      end else begin
        n_cmp++;
        if (lat != req_lat) begin
          n_fail++;
          $display("FAIL %s_latency: got %0d required %0d", name, lat, req_lat);
        end
        n_cmp++;
        if (r !== e) begin
          n_fail++;
          $display("FAIL %s_resp: got %h required %h", name, r, e);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        yumi_pulse(z);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bp_cce_mem_msg_s z_msg;
    z_msg = '0;
    drive(L4, 1'b0, z_msg); drive(L0, 1'b0, z_msg);
    set_yumi(L4, 1'b0); set_yumi(L0, 1'b0);
    #1 reset = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    for (int z = 0; z < 2; z++) begin
      n_cmp += 4;
      if (get_ready(1'(z)) !== 1'b0) begin n_fail++; $display("FAIL rst_ready[%0d]: got %b required 0", z, get_ready(1'(z))); end
      if (get_v(1'(z)) !== 1'b0)     begin n_fail++; $display("FAIL rst_v[%0d]: got %b required 0", z, get_v(1'(z))); end
      if (get_busy(1'(z)) !== 1'b0)  begin n_fail++; $display("FAIL rst_busy[%0d]: got %b required 0", z, get_busy(1'(z))); end
      if (get_resp(1'(z)) !== z_msg) begin n_fail++; $display("FAIL rst_resp[%0d]: got %h required 0", z, get_resp(1'(z))); end
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int z = 0; z < 2; z++) begin
      n_cmp += 3;
      if (get_ready(1'(z)) !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready[%0d]: got %b required 1", z, get_ready(1'(z))); end
      if (get_busy(1'(z)) !== 1'b0)  begin n_fail++; $display("FAIL post_rst_busy[%0d]: got %b required 0", z, get_busy(1'(z))); end
      if (get_v(1'(z)) !== 1'b0)     begin n_fail++; $display("FAIL post_rst_v[%0d]: got %b required 0", z, get_v(1'(z))); end
    end
  endtask

  task automatic test_wb_rd();
    bp_cce_mem_msg_s m, r;
    logic [cce_block_width_p-1:0] a5;
    a5 = {64{8'hA5}};
    m = mk_msg(e_cce_mem_wb, 40'h40, e_mem_size_8);
    m.data = a5;
    xact(L4, m, "wb40", r);
    n_cmp++;
    if (r.data !== '0) begin n_fail++; $display("FAIL wb40_data: got %h required 0", r.data); end
    m = mk_msg(e_cce_mem_rd, 40'h48, e_mem_size_8);
    xact(L4, m, "rd48", r);
    n_cmp += 3;
    if (r.data !== a5) begin n_fail++; $display("FAIL rd48_data: got %h required %h", r.data, a5); end
    if (r.addr !== 40'h48) begin n_fail++; $display("FAIL rd48_addr: got %h required 48", r.addr); end
    if (r.payload !== m.payload) begin n_fail++; $display("FAIL rd48_payload: got %h required %h", r.payload, m.payload); end
  endtask

  task automatic test_uncached();
    bp_cce_mem_msg_s m, r;
    m = mk_msg(e_cce_mem_wb, 40'h80, e_mem_size_8);
    xact(L4, m, "uc_pre_wb", r);
    m = mk_msg(e_cce_mem_uc_wr, 40'h86, e_mem_size_2);
    m.data[63:0] = 64'h0000_0000_0000_BEEF;
    xact(L4, m, "uc_wr86", r);
    m = mk_msg(e_cce_mem_uc_rd, 40'h80, e_mem_size_8);
    xact(L4, m, "uc_rd80", r);
    m = mk_msg(e_cce_mem_rd, 40'h80, e_mem_size_8);
    xact(L4, m, "uc_blk80", r);
    for (int i = 0; i < 8; i++) begin
      m = mk_msg((i % 2 == 0) ? e_cce_mem_uc_wr : e_cce_mem_uc_rd,
                 40'h80 + 40'($urandom_range(0, 63)),
                 bp_cce_mem_req_size_e'($urandom_range(0, 3)));
      xact(L4, m, "uc_rand", r);
    end
    m = mk_msg(e_cce_mem_rd, 40'h80, e_mem_size_8);
    xact(L4, m, "uc_blk80_end", r);
  endtask

  task automatic test_backpressure();
    bp_cce_mem_msg_s m1, m2, e1, e2, r;
    bit ok, got;
    int lat;
    m1 = mk_msg(e_cce_mem_rd, 40'h80, e_mem_size_8);
    m2 = mk_msg(e_cce_mem_rd, 40'h40, e_mem_size_8);
    issue(L4, m1, ok);
    model_apply(L4, m1, e1);
    wait_resp(L4, 64, got, lat, r);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL bp_first_resp: valid=0, required 1"); end
    drive(L4, 1'b1, m2);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp += 3;
      if (if4.mem_resp_v !== 1'b1)    begin n_fail++; $display("FAIL bp_hold_v c%0d: got %b required 1", c, if4.mem_resp_v); end
      if (if4.mem_resp !== e1)        begin n_fail++; $display("FAIL bp_hold_data c%0d: got %h required %h", c, if4.mem_resp, e1); end
      if (if4.mem_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready c%0d: got %b required 0", c, if4.mem_cmd_ready); end
    end
    @(negedge clk);
    yumi_pulse(L4);
    @(negedge clk);
    n_cmp += 3;
    if (if4.mem_resp_v !== 1'b0)    begin n_fail++; $display("FAIL bp_after_yumi_v: got %b required 0", if4.mem_resp_v); end
    if (if4.mem_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_yumi_ready: got %b required 1", if4.mem_cmd_ready); end
    if (busy4 !== 1'b0)             begin n_fail++; $display("FAIL bp_after_yumi_busy: got %b required 0", busy4); end
    @(posedge clk);
    model_apply(L4, m2, e2);
    #1 drive(L4, 1'b0, m2);
    @(negedge clk);
    n_cmp += 2;
    if (busy4 !== 1'b1)             begin n_fail++; $display("FAIL bp_second_busy: got %b required 1", busy4); end
    if (if4.mem_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_ready: got %b required 0", if4.mem_cmd_ready); end
    wait_resp(L4, 64, got, lat, r);
    n_cmp += 2;
    // One post-accept negedge was already consumed above.
    if (!got || lat + 1 != 4) begin n_fail++; $display("FAIL bp_second_latency: got %0d required 4 (got=%b)", lat + 1, got); end
    if (r !== e2) begin n_fail++; $display("FAIL bp_second_resp: got %h required %h", r, e2); end
    yumi_pulse(L4);
  endtask

  task automatic test_back_to_back();
    bp_cce_mem_msg_s m, e, r;
    logic [MSG_W-1:0] ev;
    int issued, last_acc;
    for (int b = 0; b < 4; b++) begin
      m = mk_msg(e_cce_mem_wb, 40'h100 + 40'(b * 64), e_mem_size_8);
      xact(L0, m, "b2b_pre_wb", r);
    end
    issued = 0;
    last_acc = -100;
    for (int c = 0; c < 60 && (issued < 8 || exp_q.size() > 0); c++) begin
      @(negedge clk);
      set_yumi(L0, if0.mem_resp_v);
      if (if0.mem_resp_v) begin
        n_cmp += 2;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_resp: got %h required none", if0.mem_resp);
        end else begin
          ev = exp_q.pop_front();
          if (if0.mem_resp !== ev) begin n_fail++; $display("FAIL b2b_resp: got %h required %h", if0.mem_resp, ev); end
        end
        if (c != last_acc + 1) begin n_fail++; $display("FAIL b2b_resp_cycle: got %0d required %0d", c, last_acc + 1); end
      end
      if (if0.mem_cmd_ready && issued < 8) begin
        if (issued > 0) begin
          n_cmp++;
          if (c - last_acc != 2) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d required 2", c - last_acc); end
        end
        m = mk_msg(e_cce_mem_rd, 40'h100 + 40'($urandom_range(0, 255)), e_mem_size_8);
        drive(L0, 1'b1, m);
        model_apply(L0, m, e);
        exp_q.push_back(e);
        last_acc = c;
        issued++;
      end else begin
        drive(L0, 1'b0, m);
      end
    end
    @(negedge clk);
    set_yumi(L0, 1'b0);
    drive(L0, 1'b0, m);
    n_cmp++;
    if (issued != 8 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: issued %0d pending %0d required 8 and 0", issued, exp_q.size());
    end
  endtask

  task automatic test_alias();
    bp_cce_mem_msg_s m, w, r;
    w = mk_msg(e_cce_mem_wb, 40'h0000, e_mem_size_8);
    xact(L4, w, "alias_wb", r);
    m = mk_msg(e_cce_mem_rd, 40'h1000, e_mem_size_8);
    xact(L4, m, "alias_rd", r);
    n_cmp++;
    if (r.data !== w.data) begin n_fail++; $display("FAIL alias_data: got %h required %h", r.data, w.data); end
  endtask

  task automatic test_reset_mid();
    bp_cce_mem_msg_s m, r;
    bit ok, seen;
    m = mk_msg(e_cce_mem_rd, 40'h40, e_mem_size_8);
    issue(L4, m, ok);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp += 3;
    if (if4.mem_resp_v !== 1'b0)    begin n_fail++; $display("FAIL rstmid_v: got %b required 0", if4.mem_resp_v); end
    if (busy4 !== 1'b0)             begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy4); end
    if (if4.mem_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b required 0", if4.mem_cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if4.mem_resp_v) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL rstmid_stale_resp: valid seen=1 required 0"); end
    m = mk_msg(e_cce_mem_rd, 40'h40, e_mem_size_8);
    xact(L4, m, "rstmid_rd", r);
    n_cmp++;
    if (r.data !== '0) begin n_fail++; $display("FAIL rstmid_rd_data: got %h required 0", r.data); end
  endtask

  task automatic test_random();
    bp_cce_mem_msg_s m, r;
    bp_cce_mem_cmd_type_e t;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 24; i++) begin
        t = bp_cce_mem_cmd_type_e'($urandom_range(0, 4));
        m = mk_msg(t, 40'($urandom_range(0, 16'hFFFF)),
                   bp_cce_mem_req_size_e'($urandom_range(0, 3)));
        xact(1'(z), m, "rand", r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_rd();
    test_uncached();
    test_backpressure();
    test_back_to_back();
    test_alias();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
